uart_transmitter: RTL

Serial transmit stage of the UART. It takes a byte from NIOS and shifts it out as one asynchronous frame on `serial_out`, formatted by the same 8-bit `usr_options` register that configures the receive path. That register sets parity, data width, stop bits, handshake and baud rate. The block generates its own bit timing from `sys_clk` and reports completion with a one-cycle `tx_done` pulse.

---
 rtl/uart_transmitter_if.sv | 21 ++
 rtl/uart_transmitter.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_transmitter_if.sv
// NIOS-side request/configuration signals and serial-line outputs of the UART transmitter.
// The master drives requests and options; the slave is the transmitter itself.
interface uart_transmitter_if;
    logic [7:0] usr_options;
    logic [7:0] data_out_nios;
    logic       send_data;
    logic       cts_n;
    logic       serial_out;
    logic       tx_busy;
    logic       tx_done;

    modport master (
        output usr_options, data_out_nios, send_data, cts_n,
        input  serial_out, tx_busy, tx_done
    );

    modport slave (
        input  usr_options, data_out_nios, send_data, cts_n,
        output serial_out, tx_busy, tx_done
    );
endinterface

// File: rtl/uart_transmitter.sv
// UART transmit stage: frames one byte per request using the latched usr_options format.
// Define UART_TX_HANDSHAKE_EN to gate requests on a synchronized cts_n when usr_options[5]=1.
module uart_transmitter #(
    parameter int CLK_FREQ = 50_000_000
) (
    input logic               sys_clk,
    input logic               reset,
    uart_transmitter_if.slave bus
);
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    localparam logic [15:0] DIV_M1_9600   = 16'(CLK_FREQ / 9600 - 1);
    localparam logic [15:0] DIV_M1_19200  = 16'(CLK_FREQ / 19200 - 1);
    localparam logic [15:0] DIV_M1_57600  = 16'(CLK_FREQ / 57600 - 1);
    localparam logic [15:0] DIV_M1_115200 = 16'(CLK_FREQ / 115200 - 1);

    state_t      state_q, state_d;
    logic [15:0] baud_cnt_q, baud_cnt_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic        stop2_q, stop2_d;
    logic [7:0]  data_q, data_d;
    logic        par_en_q, par_en_d;
    logic        par_odd_q, par_odd_d;
    logic [2:0]  last_idx_q, last_idx_d;
    logic        two_stop_q, two_stop_d;
    logic [1:0]  baud_q, baud_d;
    logic        serial_out_q, serial_out_d;
    logic        tx_busy_q, tx_busy_d;
    logic        tx_done_q, tx_done_d;

    logic        hs_ok;
    logic        bit_end;
    logic        parity_bit;
    logic [2:0]  next_idx;
    logic [15:0] reload;

    function automatic logic [15:0] div_m1(input logic [1:0] sel);
        case (sel)
            2'd0:    return DIV_M1_9600;
            2'd1:    return DIV_M1_19200;
            2'd2:    return DIV_M1_57600;
            default: return DIV_M1_115200;
        endcase
    endfunction

`ifdef UART_TX_HANDSHAKE_EN
    logic cts_meta_q, cts_meta_d;
    logic cts_sync_q, cts_sync_d;

    always_comb begin
        cts_meta_d = bus.cts_n;
        cts_sync_d = cts_meta_q;
    end

    // Synchronizer resets to "not clear" so nothing is sent before cts_n has been seen low.
    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            cts_meta_q <= 1'b1;
            cts_sync_q <= 1'b1;
        end else begin
            cts_meta_q <= cts_meta_d;
            cts_sync_q <= cts_sync_d;
        end
    end

    assign hs_ok = !bus.usr_options[5] || !cts_sync_q;
`else
    logic unused_handshake;
    assign unused_handshake = bus.usr_options[5] ^ bus.cts_n;
    assign hs_ok = 1'b1;
`endif

    // Parity covers only the configured data width of the latched byte.
    always_comb begin
        parity_bit = par_odd_q;
        for (int i = 0; i < 8; i++) begin
            if (3'(i) <= last_idx_q) begin
                parity_bit = parity_bit ^ data_q[i];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        baud_cnt_d   = baud_cnt_q;
        bit_idx_d    = bit_idx_q;
        stop2_d      = stop2_q;
        data_d       = data_q;
        par_en_d     = par_en_q;
        par_odd_d    = par_odd_q;
        last_idx_d   = last_idx_q;
        two_stop_d   = two_stop_q;
        baud_d       = baud_q;
        serial_out_d = serial_out_q;
        tx_busy_d    = tx_busy_q;
        tx_done_d    = 1'b0;
        bit_end      = (baud_cnt_q == 16'd0);
        next_idx     = bit_idx_q + 3'd1;
        reload       = div_m1(baud_q);

        if (state_q != IDLE && !bit_end) begin
            baud_cnt_d = baud_cnt_q - 16'd1;
        end

        case (state_q)
            IDLE: begin
                if (bus.send_data && hs_ok) begin
                    data_d       = bus.data_out_nios;
                    par_en_d     = bus.usr_options[0];
                    par_odd_d    = bus.usr_options[1];
                    last_idx_d   = 3'd7 - {1'b0, bus.usr_options[3:2]};
                    two_stop_d   = bus.usr_options[4];
                    baud_d       = bus.usr_options[7:6];
                    baud_cnt_d   = div_m1(bus.usr_options[7:6]);
                    serial_out_d = 1'b0;
                    tx_busy_d    = 1'b1;
                    state_d      = START;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d      = DATA;
                    bit_idx_d    = 3'd0;
                    serial_out_d = data_q[0];
                    baud_cnt_d   = reload;
                end
            end
            DATA: begin
                if (bit_end) begin
                    baud_cnt_d = reload;
                    if (bit_idx_q == last_idx_q) begin
                        if (par_en_q) begin
                            state_d      = PARITY;
                            serial_out_d = parity_bit;
                        end else begin
                            state_d      = STOP;
                            serial_out_d = 1'b1;
                            stop2_d      = 1'b0;
                        end
                    end else begin
                        bit_idx_d    = next_idx;
                        serial_out_d = data_q[next_idx];
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_d      = STOP;
                    serial_out_d = 1'b1;
                    stop2_d      = 1'b0;
                    baud_cnt_d   = reload;
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (two_stop_q && !stop2_q) begin
                        stop2_d    = 1'b1;
                        baud_cnt_d = reload;
                    end else begin
                        state_d    = IDLE;
                        tx_busy_d  = 1'b0;
                        tx_done_d  = 1'b1;
                        baud_cnt_d = 16'd0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            baud_cnt_q   <= 16'd0;
            bit_idx_q    <= 3'd0;
            stop2_q      <= 1'b0;
            data_q       <= 8'd0;
            par_en_q     <= 1'b0;
            par_odd_q    <= 1'b0;
            last_idx_q   <= 3'd7;
            two_stop_q   <= 1'b0;
            baud_q       <= 2'd0;
            serial_out_q <= 1'b1;
            tx_busy_q    <= 1'b0;
            tx_done_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            baud_cnt_q   <= baud_cnt_d;
            bit_idx_q    <= bit_idx_d;
            stop2_q      <= stop2_d;
            data_q       <= data_d;
            par_en_q     <= par_en_d;
            par_odd_q    <= par_odd_d;
            last_idx_q   <= last_idx_d;
            two_stop_q   <= two_stop_d;
            baud_q       <= baud_d;
            serial_out_q <= serial_out_d;
            tx_busy_q    <= tx_busy_d;
            tx_done_q    <= tx_done_d;
        end
    end

    assign bus.serial_out = serial_out_q;
    assign bus.tx_busy    = tx_busy_q;
    assign bus.tx_done    = tx_done_q;
endmodule
